// File: rtl/reorder_buffer_if.sv
// Reorder buffer bus bundle: allocation, three writeback result buses, two operand lookups and
// the registered commit stream toward the architectural register file.
//   master : dispatch / reservation-station side (drives alloc, writeback, query tags, flush)
//   slave  : the reorder buffer itself
interface reorder_buffer_if;
  logic        flush;

  logic        alloc_en;
  logic [4:0]  alloc_rd;
  logic [4:0]  alloc_tag;
  logic        full;
  logic        empty;

  logic        writeback1_en;
  logic [4:0]  writeback1_vregid;
  logic [31:0] writeback1_val;
  logic        writeback2_en;
  logic [4:0]  writeback2_vregid;
  logic [31:0] writeback2_val;
  logic        writeback3_en;
  logic [4:0]  writeback3_vregid;
  logic [31:0] writeback3_val;

  logic [4:0]  query1_tag;
  logic        query1_ready;
  logic [31:0] query1_val;
  logic [4:0]  query2_tag;
  logic        query2_ready;
  logic [31:0] query2_val;

  logic        commit_en;
  logic [4:0]  commit_rd;
  logic [4:0]  commit_tag;
  logic [31:0] commit_val;

  modport master (
    output flush, alloc_en, alloc_rd,
    output writeback1_en, writeback1_vregid, writeback1_val,
    output writeback2_en, writeback2_vregid, writeback2_val,
    output writeback3_en, writeback3_vregid, writeback3_val,
    output query1_tag, query2_tag,
    input  alloc_tag, full, empty,
    input  query1_ready, query1_val, query2_ready, query2_val,
    input  commit_en, commit_rd, commit_tag, commit_val
  );

  modport slave (
    input  flush, alloc_en, alloc_rd,
    input  writeback1_en, writeback1_vregid, writeback1_val,
    input  writeback2_en, writeback2_vregid, writeback2_val,
    input  writeback3_en, writeback3_vregid, writeback3_val,
    input  query1_tag, query2_tag,
    output alloc_tag, full, empty,
    output query1_ready, query1_val, query2_ready, query2_val,
    output commit_en, commit_rd, commit_tag, commit_val
  );
endinterface

// File: rtl/reorder_buffer.sv
// 32-entry circular reorder buffer. Hands out 5-bit tags (the tail pointer) at dispatch,
// collects results from three writeback buses, answers two operand lookups (with same-cycle
// writeback bypass) and retires ready entries in program order, one per cycle.
// Ports:
//   clk   : clock, rising edge
//   rst_n : asynchronous active-low reset
//   rob   : reorder_buffer_if.slave bundle (alloc, writeback 1..3, query 1..2, commit, flush)
module reorder_buffer (
  input logic            clk,
  input logic            rst_n,
  reorder_buffer_if.slave rob
);

  localparam int unsigned Depth = 32;

  logic [Depth-1:0] valid_q, valid_d;
  logic [Depth-1:0] ready_q, ready_d;
  logic [4:0]       rd_q  [Depth];
  logic [31:0]      val_q [Depth];

  logic [4:0]  head_q, head_d;
  logic [4:0]  tail_q, tail_d;
  logic [5:0]  count_q, count_d;

  logic        commit_en_q, commit_en_d;
  logic [4:0]  commit_rd_q, commit_rd_d;
  logic [4:0]  commit_tag_q, commit_tag_d;
  logic [31:0] commit_val_q, commit_val_d;

  logic        full, alloc_ok, do_commit;
  logic [2:0]  wb_en, wb_acc;
  logic [4:0]  wb_tag [3];
  logic [31:0] wb_val [3];

  assign wb_en[0]  = rob.writeback1_en;
  assign wb_en[1]  = rob.writeback2_en;
  assign wb_en[2]  = rob.writeback3_en;
  assign wb_tag[0] = rob.writeback1_vregid;
  assign wb_tag[1] = rob.writeback2_vregid;
  assign wb_tag[2] = rob.writeback3_vregid;
  assign wb_val[0] = rob.writeback1_val;
  assign wb_val[1] = rob.writeback2_val;
  assign wb_val[2] = rob.writeback3_val;

  assign full          = (count_q == 6'd32);
  assign rob.full      = full;
  assign rob.empty     = (count_q == 6'd0);
  assign rob.alloc_tag = tail_q;

  assign alloc_ok  = rob.alloc_en && !full && !rob.flush;
  assign do_commit = valid_q[head_q] && ready_q[head_q] && !rob.flush;

  // A writeback only lands on an allocated, still-pending entry; later results are dropped.
  always_comb begin
    wb_acc = '0;
    for (int k = 0; k < 3; k++) begin
      wb_acc[k] = wb_en[k] && valid_q[wb_tag[k]] && !ready_q[wb_tag[k]] && !rob.flush;
    end
  end

  always_comb begin
    valid_d      = valid_q;
    ready_d      = ready_q;
    head_d       = head_q;
    tail_d       = tail_q;
    count_d      = count_q;
    commit_en_d  = 1'b0;
    commit_rd_d  = commit_rd_q;
    commit_tag_d = commit_tag_q;
    commit_val_d = commit_val_q;
    if (rob.flush) begin
      valid_d = '0;
      ready_d = '0;
      head_d  = '0;
      tail_d  = '0;
      count_d = '0;
    end else begin
      // Tail entry is never valid when not full, so alloc cannot collide with a writeback.
      if (alloc_ok) begin
        valid_d[tail_q] = 1'b1;
        ready_d[tail_q] = 1'b0;
        tail_d          = tail_q + 5'd1;
      end
      for (int k = 0; k < 3; k++) begin
        if (wb_acc[k]) ready_d[wb_tag[k]] = 1'b1;
      end
      if (do_commit) begin
        valid_d[head_q] = 1'b0;
        head_d          = head_q + 5'd1;
        commit_en_d     = 1'b1;
        commit_rd_d     = rd_q[head_q];
        commit_tag_d    = head_q;
        commit_val_d    = val_q[head_q];
      end
      count_d = count_q + {5'd0, alloc_ok} - {5'd0, do_commit};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q      <= '0;
      ready_q      <= '0;
      head_q       <= '0;
      tail_q       <= '0;
      count_q      <= '0;
      commit_en_q  <= 1'b0;
      commit_rd_q  <= '0;
      commit_tag_q <= '0;
      commit_val_q <= '0;
    end else begin
      valid_q      <= valid_d;
      ready_q      <= ready_d;
      head_q       <= head_d;
      tail_q       <= tail_d;
      count_q      <= count_d;
      commit_en_q  <= commit_en_d;
      commit_rd_q  <= commit_rd_d;
      commit_tag_q <= commit_tag_d;
      commit_val_q <= commit_val_d;
    end
  end

  // Payload needs no reset: it is only observed through valid/ready.
  // Writes ordered 3, 2, 1 so port 1 wins a same-tag collision.
  always_ff @(posedge clk) begin
    if (alloc_ok)  rd_q[tail_q]      <= rob.alloc_rd;
    if (wb_acc[2]) val_q[wb_tag[2]]  <= wb_val[2];
    if (wb_acc[1]) val_q[wb_tag[1]]  <= wb_val[1];
    if (wb_acc[0]) val_q[wb_tag[0]]  <= wb_val[0];
  end

  // Operand lookup: bus bypass first (port 1 highest), else stored state.
  always_comb begin
    rob.query1_ready = valid_q[rob.query1_tag] && ready_q[rob.query1_tag];
    rob.query1_val   = val_q[rob.query1_tag];
    for (int k = 2; k >= 0; k--) begin
      if (wb_en[k] && (wb_tag[k] == rob.query1_tag)) begin
        rob.query1_ready = 1'b1;
        rob.query1_val   = wb_val[k];
      end
    end
  end

  always_comb begin
    rob.query2_ready = valid_q[rob.query2_tag] && ready_q[rob.query2_tag];
    rob.query2_val   = val_q[rob.query2_tag];
    for (int k = 2; k >= 0; k--) begin
      if (wb_en[k] && (wb_tag[k] == rob.query2_tag)) begin
        rob.query2_ready = 1'b1;
        rob.query2_val   = wb_val[k];
      end
    end
  end

  assign rob.commit_en  = commit_en_q;
  assign rob.commit_rd  = commit_rd_q;
  assign rob.commit_tag = commit_tag_q;
  assign rob.commit_val = commit_val_q;

endmodule

// File: tb/tb_reorder_buffer.sv
// Directed bench for reorder_buffer: reset, single instruction, out-of-order completion,
// fill/wrap, writeback collision with bypass, flush, back-to-back throughput, async reset.
module tb_reorder_buffer;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   checks = 0;
  int   errors = 0;

  reorder_buffer_if bus ();

  reorder_buffer dut (
    .clk   (clk),
    .rst_n (rst_n),
    .rob   (bus)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    bus.flush = 1'b0;
    bus.alloc_en = 1'b0;
    bus.alloc_rd = '0;
    bus.writeback1_en = 1'b0; bus.writeback1_vregid = '0; bus.writeback1_val = '0;
    bus.writeback2_en = 1'b0; bus.writeback2_vregid = '0; bus.writeback2_val = '0;
    bus.writeback3_en = 1'b0; bus.writeback3_vregid = '0; bus.writeback3_val = '0;
    bus.query1_tag = '0;
    bus.query2_tag = '0;
  endtask

  task automatic do_reset();
    idle();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    #1;
  endtask

  task automatic test_reset();
    do_reset();
    checks++; if (bus.alloc_tag !== 5'd0) begin errors++; $display("FAIL reset_alloc_tag got %0d exp 0", bus.alloc_tag); end
    checks++; if (bus.full !== 1'b0) begin errors++; $display("FAIL reset_full got %b exp 0", bus.full); end
    checks++; if (bus.empty !== 1'b1) begin errors++; $display("FAIL reset_empty got %b exp 1", bus.empty); end
    checks++; if (bus.commit_en !== 1'b0) begin errors++; $display("FAIL reset_commit_en got %b exp 0", bus.commit_en); end
    checks++; if ({bus.commit_rd, bus.commit_tag, bus.commit_val} !== 42'd0) begin errors++; $display("FAIL reset_commit_fields got %h/%h/%h exp 0", bus.commit_rd, bus.commit_tag, bus.commit_val); end
    tick();
    checks++; if (bus.commit_en !== 1'b0 || bus.empty !== 1'b1) begin errors++; $display("FAIL reset_idle got en=%b empty=%b exp 0/1", bus.commit_en, bus.empty); end
  endtask

  task automatic test_single();
    do_reset();
    bus.alloc_en = 1'b1; bus.alloc_rd = 5'd5;
    #1;
    checks++; if (bus.alloc_tag !== 5'd0) begin errors++; $display("FAIL single_tag got %0d exp 0", bus.alloc_tag); end
    tick();  // E0
    idle();
    checks++; if (bus.empty !== 1'b0) begin errors++; $display("FAIL single_not_empty got %b exp 0", bus.empty); end
    bus.writeback1_en = 1'b1; bus.writeback1_vregid = 5'd0; bus.writeback1_val = 32'h1234;
    bus.query1_tag = 5'd0;
    #1;
    checks++; if (bus.query1_ready !== 1'b1 || bus.query1_val !== 32'h1234) begin errors++; $display("FAIL single_bypass got %b/%h exp 1/1234", bus.query1_ready, bus.query1_val); end
    tick();  // E1
    bus.writeback1_en = 1'b0;
    #1;
    checks++; if (bus.commit_en !== 1'b0) begin errors++; $display("FAIL single_early got %b exp 0", bus.commit_en); end
    checks++; if (bus.query1_ready !== 1'b1 || bus.query1_val !== 32'h1234) begin errors++; $display("FAIL single_stored got %b/%h exp 1/1234", bus.query1_ready, bus.query1_val); end
    tick();  // E2
    checks++; if ({bus.commit_en, bus.commit_rd, bus.commit_tag, bus.commit_val} !== {1'b1, 5'd5, 5'd0, 32'h1234}) begin errors++; $display("FAIL single_commit got %b/%0d/%0d/%h exp 1/5/0/1234", bus.commit_en, bus.commit_rd, bus.commit_tag, bus.commit_val); end
    checks++; if (bus.empty !== 1'b1) begin errors++; $display("FAIL single_empty_after got %b exp 1", bus.empty); end
    tick();
    checks++; if (bus.commit_en !== 1'b0 || bus.commit_val !== 32'h1234) begin errors++; $display("FAIL single_hold got %b/%h exp 0/1234", bus.commit_en, bus.commit_val); end
  endtask

  task automatic test_out_of_order();
    logic [31:0] exp_val [3];
    exp_val[0] = 32'h10; exp_val[1] = 32'h11; exp_val[2] = 32'h22;
    do_reset();
    for (int i = 0; i < 3; i++) begin
      bus.alloc_en = 1'b1; bus.alloc_rd = 5'(i + 1);
      #1;
      checks++; if (bus.alloc_tag !== 5'(i)) begin errors++; $display("FAIL ooo_tag got %0d exp %0d", bus.alloc_tag, i); end
      tick();
    end
    idle();
    bus.writeback3_en = 1'b1; bus.writeback3_vregid = 5'd2; bus.writeback3_val = 32'h22;
    tick();
    idle();
    bus.writeback2_en = 1'b1; bus.writeback2_vregid = 5'd1; bus.writeback2_val = 32'h11;
    tick();
    checks++; if (bus.commit_en !== 1'b0) begin errors++; $display("FAIL ooo_no_early got %b exp 0", bus.commit_en); end
    idle();
    bus.writeback1_en = 1'b1; bus.writeback1_vregid = 5'd0; bus.writeback1_val = 32'h10;
    tick();
    idle();
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++; if ({bus.commit_en, bus.commit_rd, bus.commit_tag, bus.commit_val} !== {1'b1, 5'(i + 1), 5'(i), exp_val[i]}) begin errors++; $display("FAIL ooo_commit%0d got %b/%0d/%0d/%h exp 1/%0d/%0d/%h", i, bus.commit_en, bus.commit_rd, bus.commit_tag, bus.commit_val, i + 1, i, exp_val[i]); end
    end
    tick();
    checks++; if (bus.commit_en !== 1'b0 || bus.empty !== 1'b1) begin errors++; $display("FAIL ooo_drained got %b/%b exp 0/1", bus.commit_en, bus.empty); end
  endtask

  task automatic test_fill_wrap();
    int bad = 0;
    do_reset();
    for (int i = 0; i < 32; i++) begin
      bus.alloc_en = 1'b1; bus.alloc_rd = 5'(i);
      #1;
      if (bus.alloc_tag !== 5'(i) || bus.full !== 1'b0) bad++;
      tick();
    end
    checks++; if (bad != 0) begin errors++; $display("FAIL fill_tags got %0d bad exp 0", bad); end
    checks++; if (bus.full !== 1'b1 || bus.alloc_tag !== 5'd0) begin errors++; $display("FAIL fill_full got %b/%0d exp 1/0", bus.full, bus.alloc_tag); end
    // 33rd alloc held while full, with writeback of head
    bus.alloc_rd = 5'd7;
    bus.writeback1_en = 1'b1; bus.writeback1_vregid = 5'd0; bus.writeback1_val = 32'h55;
    tick();
    bus.writeback1_en = 1'b0;
    #1;
    checks++; if (bus.full !== 1'b1 || bus.alloc_tag !== 5'd0) begin errors++; $display("FAIL fill_ignored got %b/%0d exp 1/0", bus.full, bus.alloc_tag); end
    tick();  // commit while still full: held alloc must be ignored
    checks++; if ({bus.commit_en, bus.commit_rd, bus.commit_tag, bus.commit_val} !== {1'b1, 5'd0, 5'd0, 32'h55}) begin errors++; $display("FAIL fill_commit got %b/%0d/%0d/%h exp 1/0/0/55", bus.commit_en, bus.commit_rd, bus.commit_tag, bus.commit_val); end
    checks++; if (bus.full !== 1'b0 || bus.alloc_tag !== 5'd0) begin errors++; $display("FAIL fill_wrap_tag got %b/%0d exp 0/0", bus.full, bus.alloc_tag); end
    tick();  // held alloc now accepted into tag 0
    bus.alloc_en = 1'b0;
    #1;
    checks++; if (bus.full !== 1'b1 || bus.alloc_tag !== 5'd1) begin errors++; $display("FAIL fill_refill got %b/%0d exp 1/1", bus.full, bus.alloc_tag); end
  endtask

  task automatic test_collision();
    logic [31:0] exp_val [5];
    exp_val[0] = 32'hC0; exp_val[1] = 32'h11; exp_val[2] = 32'h22;
    exp_val[3] = 32'h33; exp_val[4] = 32'hA;
    do_reset();
    for (int i = 0; i < 5; i++) begin
      bus.alloc_en = 1'b1; bus.alloc_rd = 5'(i + 1);
      tick();
    end
    idle();
    bus.writeback1_en = 1'b1; bus.writeback1_vregid = 5'd4; bus.writeback1_val = 32'hA;
    bus.writeback2_en = 1'b1; bus.writeback2_vregid = 5'd0; bus.writeback2_val = 32'hC0;
    bus.writeback3_en = 1'b1; bus.writeback3_vregid = 5'd4; bus.writeback3_val = 32'hB;
    bus.query1_tag = 5'd4; bus.query2_tag = 5'd3;
    #1;
    checks++; if (bus.query1_ready !== 1'b1 || bus.query1_val !== 32'hA) begin errors++; $display("FAIL coll_bypass got %b/%h exp 1/a", bus.query1_ready, bus.query1_val); end
    checks++; if (bus.query2_ready !== 1'b0) begin errors++; $display("FAIL coll_notready got %b exp 0", bus.query2_ready); end
    tick();
    idle();
    bus.query1_tag = 5'd4; bus.query2_tag = 5'd0;
    bus.writeback1_en = 1'b1; bus.writeback1_vregid = 5'd1; bus.writeback1_val = 32'h11;
    bus.writeback2_en = 1'b1; bus.writeback2_vregid = 5'd2; bus.writeback2_val = 32'h22;
    bus.writeback3_en = 1'b1; bus.writeback3_vregid = 5'd3; bus.writeback3_val = 32'h33;
    #1;
    checks++; if (bus.query2_ready !== 1'b1 || bus.query2_val !== 32'hC0) begin errors++; $display("FAIL coll_q2_stored got %b/%h exp 1/c0", bus.query2_ready, bus.query2_val); end
    tick();
    idle();
    bus.query1_tag = 5'd4;
    #1;
    checks++; if (bus.query1_ready !== 1'b1 || bus.query1_val !== 32'hA) begin errors++; $display("FAIL coll_stored got %b/%h exp 1/a", bus.query1_ready, bus.query1_val); end
    // Late writeback to an already-ready entry must be dropped
    bus.writeback1_en = 1'b1; bus.writeback1_vregid = 5'd4; bus.writeback1_val = 32'hEE;
    for (int i = 0; i < 5; i++) begin
      checks++; if ({bus.commit_en, bus.commit_rd, bus.commit_tag, bus.commit_val} !== {1'b1, 5'(i + 1), 5'(i), exp_val[i]}) begin errors++; $display("FAIL coll_commit%0d got %b/%0d/%0d/%h exp 1/%0d/%0d/%h", i, bus.commit_en, bus.commit_rd, bus.commit_tag, bus.commit_val, i + 1, i, exp_val[i]); end
      tick();
      bus.writeback1_en = 1'b0;
    end
  endtask

  task automatic test_flush();
    do_reset();
    for (int i = 0; i < 10; i++) begin
      bus.alloc_en = 1'b1; bus.alloc_rd = 5'(i + 3);
      tick();
    end
    idle();
    bus.writeback1_en = 1'b1; bus.writeback1_vregid = 5'd0; bus.writeback1_val = 32'h99;
    tick();
    // Head is ready now; flush must still block its commit
    idle();
    bus.flush = 1'b1;
    bus.alloc_en = 1'b1; bus.alloc_rd = 5'd3;
    bus.writeback1_en = 1'b1; bus.writeback1_vregid = 5'd6; bus.writeback1_val = 32'h66;
    tick();
    idle();
    #1;
    checks++; if (bus.empty !== 1'b1 || bus.alloc_tag !== 5'd0 || bus.full !== 1'b0) begin errors++; $display("FAIL flush_state got empty=%b tag=%0d full=%b exp 1/0/0", bus.empty, bus.alloc_tag, bus.full); end
    checks++; if (bus.commit_en !== 1'b0 || bus.commit_val !== 32'h0) begin errors++; $display("FAIL flush_commit got %b/%h exp 0/0", bus.commit_en, bus.commit_val); end
    bus.writeback1_en = 1'b1; bus.writeback1_vregid = 5'd5; bus.writeback1_val = 32'h77;
    tick();
    idle();
    bus.query1_tag = 5'd5;
    #1;
    checks++; if (bus.query1_ready !== 1'b0) begin errors++; $display("FAIL flush_query got %b exp 0", bus.query1_ready); end
    tick();
    checks++; if (bus.commit_en !== 1'b0 || bus.empty !== 1'b1) begin errors++; $display("FAIL flush_stale_wb got %b/%b exp 0/1", bus.commit_en, bus.empty); end
  endtask

  task automatic test_back_to_back();
    int bad = 0;
    do_reset();
    for (int c = 0; c < 9; c++) begin
      idle();
      if (c < 6) begin bus.alloc_en = 1'b1; bus.alloc_rd = 5'(c + 10); end
      if (c >= 1 && c <= 6) begin
        bus.writeback1_en = 1'b1; bus.writeback1_vregid = 5'(c - 1);
        bus.writeback1_val = 32'h100 + 32'(c - 1);
      end
      tick();
      if (c >= 2 && c <= 7) begin
        if ({bus.commit_en, bus.commit_rd, bus.commit_tag, bus.commit_val} !==
            {1'b1, 5'(c + 8), 5'(c - 2), 32'h100 + 32'(c - 2)}) bad++;
      end else if (bus.commit_en !== 1'b0) bad++;
    end
    checks++; if (bad != 0) begin errors++; $display("FAIL b2b_stream got %0d bad cycles exp 0", bad); end
    checks++; if (bus.empty !== 1'b1 || bus.alloc_tag !== 5'd6) begin errors++; $display("FAIL b2b_end got %b/%0d exp 1/6", bus.empty, bus.alloc_tag); end
  endtask

  task automatic test_async_reset();
    do_reset();
    for (int i = 0; i < 3; i++) begin
      bus.alloc_en = 1'b1; bus.alloc_rd = 5'd1;
      tick();
    end
    idle();
    #2;
    rst_n = 1'b0;
    #1;
    checks++; if (bus.empty !== 1'b1 || bus.alloc_tag !== 5'd0 || bus.commit_en !== 1'b0) begin errors++; $display("FAIL async_reset got %b/%0d/%b exp 1/0/0", bus.empty, bus.alloc_tag, bus.commit_en); end
    tick();
    rst_n = 1'b1;
  endtask

  initial begin
    idle();
    test_reset();
    test_single();
    test_out_of_order();
    test_fill_wrap();
    test_collision();
    test_flush();
    test_back_to_back();
    test_async_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/reorder_buffer.md
# reorder_buffer

32-entry circular reorder buffer that allocates the 5-bit virtual register tags (vregid) used by the dispatch stage and the reservation stations, collects results from the three writeback buses, and retires results in program order to the architectural register file. Sits downstream of the ALU, multiply and load/store reservation stations, whose writeback outputs drive its writeback ports. Sits alongside dispatch, which uses its operand lookup ports to decide whether each source operand is dependent (tag) or ready (value).

## Interface
Parameters: none; depth fixed at 32 entries, tag width 5.

Ports:
- clk  in  1  clock; all state updates on the rising edge
- rst  in  1  reset, asynchronous, active-low
- flush  in  1  synchronous pipeline flush, e.g. branch mispredict
- alloc_en  in  1  allocate one entry this cycle
- alloc_rd  in  5  architectural destination register of the allocated instruction
- alloc_tag  out  5  tag to be assigned if allocated this cycle; equals tail pointer
- full  out  1  all 32 entries occupied
- empty  out  1  no entries occupied
- writeback1_en / writeback1_vregid / writeback1_val  in  1/5/32  result bus 1
- writeback2_en / writeback2_vregid / writeback2_val  in  1/5/32  result bus 2
- writeback3_en / writeback3_vregid / writeback3_val  in  1/5/32  result bus 3
- query1_tag, query2_tag  in  5  operand lookup tags
- query1_ready, query2_ready  out  1  result for the tag is available
- query1_val, query2_val  out  32  result value; valid only when ready
- commit_en  out  1  registered; one entry retired
- commit_rd  out  5  registered; architectural destination of retired entry
- commit_tag  out  5  registered; tag of retired entry, for rename-table release
- commit_val  out  32  registered; retired value

## Operation
- Per entry state: valid, ready, rd[4:0], val[31:0].
- Pointers: head[4:0] and tail[4:0], each wrapping 31 -> 0; count[5:0] ranges 0..32.
- Flags: full = (count == 32); empty = (count == 0). Both combinational from registered count.
- Allocation: when alloc_en && !full && !flush, at the edge entry[tail] becomes valid=1, ready=0, rd=alloc_rd, and tail increments.
  - alloc_en while full is ignored and does not change state, even if a commit occurs in the same cycle.
  - The sender must hold alloc_en until full is low.
- Writeback: for port k, if en && entry[vregid].valid && !entry[vregid].ready, the entry is set ready=1 and val=value.
  - Writebacks to invalid entries are dropped.
  - If several ports name the same tag in one cycle, port 1 beats port 2, which beats port 3.
  - Distinct tags on all three ports are all accepted in the same cycle.
- Commit: when entry[head].valid && entry[head].ready && !flush, at the edge:
  - commit_en <= 1; commit_rd, commit_tag and commit_val are loaded from entry[head].
  - entry[head].valid <= 0; head increments.
  - Otherwise commit_en <= 0, and the other commit outputs hold their previous values.
  - At most one commit per cycle. rd = 0 entries are committed normally; the register file ignores x0.
- Count: count += (alloc accepted) - (commit performed); simultaneous alloc and commit leave count unchanged.
- Query (combinational), for tag t:
  - If writeback port 1, 2 or 3 matches t this cycle with en high, ready = 1 and val = that port's value (same priority order).
  - Else ready = entry[t].valid && entry[t].ready, and val = entry[t].val.
- Flush: all valid <= 0, head = tail = 0, count = 0, commit_en <= 0. Allocation and writebacks in the flush cycle are discarded. Flush has priority over everything except reset.

## Timing
- Reset (asynchronous, rst low): all valid/ready cleared, head = tail = count = 0, commit_en = 0, commit_rd = 0, commit_tag = 0, commit_val = 0. Consequently full = 0, empty = 1, alloc_tag = 0. Reset mid-operation discards all in-flight entries immediately.
- alloc_tag is valid combinationally in the same cycle as alloc_en.
- Latency: an entry allocated at edge E0 and written back at edge E1 (the earliest) is committed at edge E2, so commit_en is high during the cycle after E2.
- Sustained throughput: one allocation and one commit per cycle.
- Query bypass covers the cycle in which the writeback is on the bus; from the next cycle on, the stored value answers.

## Test plan
- Reset then idle: alloc_tag=0, full=0, empty=1, commit_en=0.
- Allocate rd=5 (tag 0), writeback1 tag 0 val 0x1234: commit_en=1 with commit_rd=5, commit_tag=0, commit_val=0x1234 in the cycle after the edge following writeback; empty=1 afterwards.
- Out-of-order completion: allocate tags 0,1,2; write back 2, then 1, then 0 on different ports; commits occur in order 0,1,2 on three consecutive cycles.
- Fill 32 entries: full=1, and a 33rd alloc_en is ignored (tail stays 0). Commit one entry: full=0, next alloc receives tag 0, confirming wrap-around.
- Same-cycle collision: ports 1 and 3 both write tag 4 (values 0xA and 0xB); stored/committed value is 0xA. query1_tag=4 during that cycle returns ready=1, val=0xA.
- Flush with 10 in-flight entries and a pending alloc: empty=1, alloc_tag=0, commit_en=0 next cycle, and a later writeback to a flushed tag produces no commit.
